mem_port_arbiter: RTL

//  Shares one single-ported backing memory between the pipelined machine's instruction-fetch

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_timeout_ctr.sv | 37 +++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_arb_pkg                                                      |
// | Brief   : Shared state encoding and port ids for the memory port arbiter.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY_IF = 2'd1;
    localparam logic [1:0] c_BUSY_D  = 2'd2;

    localparam logic c_PORT_IF = 1'b0;
    localparam logic c_PORT_D  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/arb_timeout_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : arb_timeout_ctr                                                  |
// | Brief   : 4-bit busy-cycle counter with clear, enable and terminal count.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module arb_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [3:0] r_count;
    logic [3:0] w_count_inc;

    assign w_count_inc = r_count + 4'd1;

    // Terminal count fires in the cycle whose increment reaches TIMEOUT, so the
    // abort lands in the TIMEOUT-th busy cycle; a cycle with mem_ack never counts.
    assign o_tc = i_en && (w_count_inc == 4'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 4'd0;
        end else if (i_clr) begin
            r_count <= 4'd0;
        end else if (i_en) begin
            r_count <= w_count_inc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_port_arbiter                                                 |
// | Brief   : Shares one single-ported memory between fetch and data ports.    |
// |           Optional macro ARB_RR_EN: round-robin tie break (else D wins).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          err
);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          w_grant_valid;
    logic          w_grant_port;
    logic          w_grant;
    logic          w_busy;
    logic          w_busy_if;
    logic          w_busy_d;
    logic          w_mem_hit;
    logic          w_tc;
    logic          w_timeout;
    logic          w_done;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_err;

    assign w_busy_if = (r_state == c_BUSY_IF);
    assign w_busy_d  = (r_state == c_BUSY_D);
    assign w_busy    = w_busy_if | w_busy_d;
    assign w_mem_hit = w_busy & mem_ack;
    assign w_timeout = w_busy & w_tc;
    assign w_done    = w_mem_hit | w_timeout;
    assign w_grant   = (r_state == c_IDLE) & w_grant_valid;

`ifdef ARB_RR_EN
    logic r_last_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= c_PORT_IF;
        end else if (w_grant) begin
            r_last_grant <= w_grant_port;
        end
    end
`endif

    always_comb begin
        w_grant_valid = if_req | d_req;
        w_grant_port  = c_PORT_IF;
        if (if_req && d_req) begin
`ifdef ARB_RR_EN
            w_grant_port = ~r_last_grant;
`else
            // Data access belongs to the older instruction in the pipe.
            w_grant_port = c_PORT_D;
`endif
        end else if (d_req) begin
            w_grant_port = c_PORT_D;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt = (w_grant_port == c_PORT_D) ? c_BUSY_D : c_BUSY_IF;
                end
            end
            c_BUSY_IF, c_BUSY_D: begin
                if (w_done) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Transaction is captured at grant; port inputs are ignored while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant) begin
            if (w_grant_port == c_PORT_D) begin
                r_mem_we    <= d_we;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
            end else begin
                r_mem_we    <= 1'b0;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    arb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .reset (reset),
        .i_clr (~w_busy),
        .i_en  (w_busy & ~mem_ack),
        .o_tc  (w_tc)
    );

    // An aborted access returns zero data rather than whatever is on the bus.
    assign if_ack   = w_busy_if & w_done;
    assign d_ack    = w_busy_d  & w_done;
    assign if_rdata = (w_busy_if && mem_ack) ? mem_rdata : '0;
    assign d_rdata  = (w_busy_d  && mem_ack) ? mem_rdata : '0;
    assign if_stall = if_req & ~if_ack;
    assign d_stall  = d_req  & ~d_ack;

    assign mem_req   = w_busy;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;

endmodule
`default_nettype wire
